// File: rtl/alu_pipe.sv
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Handshaked, registered ALU. Takes one operation per valid/ready
//             transfer and returns the result with zero/carry/overflow/negative
//             flags on a valid/ready output. Single-cycle ops sustain one result
//             per clock; ALU_MUL is an iterative shift-add taking WIDTH+1
//             cycles.
//  Ports    : clk, reset (async, active-high)
//             in_valid / in_ready          : operation handshake
//             op1, op2, operation          : operands and opcode
//             out_valid / out_ready        : result handshake
//             result, zero, carry,
//             overflow, negative           : registered result and flags
//             busy                         : high while multiplying
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Opcode set of the original combinational ALU, extended with shifts and the
// iterative multiply. The 4-bit base leaves room for undefined encodings,
// which produce a zero result.
typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_LT  = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_MUL = 4'd8
} alu_operation_t;

module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    input  alu_operation_t    operation,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              carry,
    output logic              overflow,
    output logic              negative,
    output logic              busy
);

    // Counter must hold the value WIDTH itself.
    localparam int c_CW  = $clog2(WIDTH + 1);
    // Shift amount is compared against WIDTH in a width that cannot truncate.
    localparam int c_EXT = 33 - WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic [c_CW-1:0]        r_cnt;

    logic [WIDTH-1:0]       r_result;
    logic                   r_zero;
    logic                   r_carry;
    logic                   r_overflow;
    logic                   r_negative;

    logic                   w_accept;
    logic                   w_is_mul;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [32:0]            w_shamt_ext;
    logic                   w_shamt_big;
    logic [WIDTH-1:0]       w_res;
    logic                   w_carry;
    logic                   w_ovf;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_mul  = (operation == ALU_MUL);

    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_MUL);
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign negative  = r_negative;

    // ------------------------------------------------------------------------
    // Single-cycle arithmetic on the live inputs; registered on the accept edge
    // ------------------------------------------------------------------------
    assign w_sum       = {1'b0, op1} + {1'b0, op2};
    // MSB of the extended difference is the unsigned borrow (op1 < op2).
    assign w_diff      = {1'b0, op1} - {1'b0, op2};
    assign w_shamt_ext = {{c_EXT{1'b0}}, op2};
    assign w_shamt_big = (w_shamt_ext >= 33'(WIDTH));

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (operation)
            ALU_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != op1[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != op1[WIDTH-1]);
            end
            ALU_AND: w_res = op1 & op2;
            ALU_OR:  w_res = op1 | op2;
            ALU_XOR: w_res = op1 ^ op2;
            ALU_LT:  w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
            ALU_SLL: w_res = w_shamt_big ? '0 : (op1 << op2);
            ALU_SRL: w_res = w_shamt_big ? '0 : (op1 >> op2);
            ALU_MUL: w_res = '0;    // handled by the iterative datapath
            default: w_res = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_nxt = w_is_mul ? S_MUL : S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: result/flag registers and the shift-add multiplier
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_negative <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_mcand  <= {{WIDTH{1'b0}}, op1};
                r_mplier <= op2;
                r_acc    <= '0;
                r_cnt    <= c_CW'(WIDTH);
            end else begin
                r_result   <= w_res;
                r_zero     <= (w_res == '0);
                r_carry    <= w_carry;
                r_overflow <= w_ovf;
                r_negative <= w_res[WIDTH-1];
            end
        end else if (r_state == S_MUL) begin
            if (r_cnt != '0) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - c_CW'(1);
            end else begin
                // Counter exhausted: the accumulator holds the full product.
                r_result   <= r_acc[WIDTH-1:0];
                r_zero     <= (r_acc[WIDTH-1:0] == '0);
                r_carry    <= |r_acc[2*WIDTH-1:WIDTH];
                r_overflow <= 1'b0;
                r_negative <= r_acc[WIDTH-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Directed self-checking bench for alu_pipe. A WIDTH=4 instance
//             covers add/sub/mul flags and MUL latency; a WIDTH=8 instance
//             covers back-to-back throughput, backpressure, reset during a
//             multiply and shift boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

    logic clk;
    logic reset;

    // WIDTH=4 instance (prefix a_)
    logic           a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]     a_op1, a_op2, a_result;
    alu_operation_t a_oper;
    logic           a_zero, a_carry, a_overflow, a_negative, a_busy;

    // WIDTH=8 instance (prefix b_)
    logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]     b_op1, b_op2, b_result;
    alu_operation_t b_oper;
    logic           b_zero, b_carry, b_overflow, b_negative, b_busy;

    int n_checks;
    int n_fail;

    alu_pipe #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .op1       (a_op1),
        .op2       (a_op2),
        .operation (a_oper),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .result    (a_result),
        .zero      (a_zero),
        .carry     (a_carry),
        .overflow  (a_overflow),
        .negative  (a_negative),
        .busy      (a_busy)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .op1       (b_op1),
        .op2       (b_op2),
        .operation (b_oper),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .result    (b_result),
        .zero      (b_zero),
        .carry     (b_carry),
        .overflow  (b_overflow),
        .negative  (b_negative),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        a_in_valid  = 1'b0; a_op1 = '0; a_op2 = '0; a_oper = ALU_ADD; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_op1 = '0; b_op2 = '0; b_oper = ALU_ADD; b_out_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_out_valid", 64'(b_out_valid), 64'd0);
        check("rst_result",    64'(b_result),    64'd0);
        check("rst_flags",     64'({b_zero, b_carry, b_overflow, b_negative}), 64'd0);
        check("rst_busy",      64'(b_busy),      64'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready4", 64'(a_in_ready), 64'd1);
        check("rst_in_ready8", 64'(b_in_ready), 64'd1);

        // ---------------- WIDTH=4 ADD 14+15 ----------------
        a_in_valid = 1'b1; a_oper = ALU_ADD; a_op1 = 4'd14; a_op2 = 4'd15;
        tick();
        a_in_valid = 1'b0;
        check("add_valid",  64'(a_out_valid), 64'd1);
        check("add_result", 64'(a_result),    64'd13);
        check("add_zcvn",   64'({a_zero, a_carry, a_overflow, a_negative}), 64'b0101);
        check("add_hold_in_ready", 64'(a_in_ready), 64'd0);

        // ---------------- SUB 10-10, then SUB 5-10, back-to-back ----------------
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1; a_oper = ALU_SUB; a_op1 = 4'd10; a_op2 = 4'd10;
        tick();
        check("sub_eq_result", 64'(a_result), 64'd0);
        check("sub_eq_zc",     64'({a_zero, a_carry}), 64'b10);
        a_op1 = 4'd5; a_op2 = 4'd10;
        tick();
        check("sub_lt_result", 64'(a_result), 64'd11);
        check("sub_lt_zcvn",   64'({a_zero, a_carry, a_overflow, a_negative}), 64'b0111);

        // ---------------- MUL 7*3 (WIDTH=4) ----------------
        a_oper = ALU_MUL; a_op1 = 4'd7; a_op2 = 4'd3;
        tick();                      // accept edge
        a_in_valid = 1'b0;
        a_op1 = 4'd0; a_op2 = 4'd0;  // later input changes must be ignored
        check("mul_busy_start", 64'({a_busy, a_in_ready, a_out_valid}), 64'b100);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("mul_wait%0d", i), 64'({a_busy, a_out_valid}), 64'b10);
        end
        tick();                      // accept + 5
        check("mul73_valid",  64'({a_out_valid, a_busy}), 64'b10);
        check("mul73_result", 64'(a_result), 64'd5);
        check("mul73_carry",  64'({a_carry, a_overflow}), 64'b10);

        // ---------------- MUL 3*5 (WIDTH=4) ----------------
        a_in_valid = 1'b1; a_oper = ALU_MUL; a_op1 = 4'd3; a_op2 = 4'd5;
        tick();
        a_in_valid = 1'b0;
        repeat (4) tick();
        check("mul35_early", 64'(a_out_valid), 64'd0);
        tick();
        check("mul35_valid",  64'(a_out_valid), 64'd1);
        check("mul35_result", 64'(a_result), 64'd15);
        check("mul35_cn",     64'({a_carry, a_negative}), 64'b01);

        // ---------------- undefined opcode ----------------
        a_in_valid = 1'b1; a_oper = alu_operation_t'(4'hF); a_op1 = 4'd5; a_op2 = 4'd6;
        tick();
        a_in_valid = 1'b0;
        check("undef_result", 64'(a_result), 64'd0);
        check("undef_zcvn",   64'({a_zero, a_carry, a_overflow, a_negative}), 64'b1000);

        // ---------------- WIDTH=8 back-to-back AND/OR/XOR ----------------
        b_out_ready = 1'b1;
        check("b2b_ready0", 64'(b_in_ready), 64'd1);
        b_in_valid = 1'b1; b_oper = ALU_AND; b_op1 = 8'hF0; b_op2 = 8'h3C;
        tick();
        check("b2b_and", 64'({b_out_valid, b_result}), {55'd0, 1'b1, 8'h30});
        check("b2b_ready1", 64'(b_in_ready), 64'd1);
        b_oper = ALU_OR;
        tick();
        check("b2b_or", 64'({b_out_valid, b_result}), {55'd0, 1'b1, 8'hFC});
        check("b2b_or_neg", 64'(b_negative), 64'd1);
        check("b2b_ready2", 64'(b_in_ready), 64'd1);
        b_oper = ALU_XOR;
        tick();
        check("b2b_xor", 64'({b_out_valid, b_result}), {55'd0, 1'b1, 8'hCC});
        check("b2b_ready3", 64'(b_in_ready), 64'd1);
        b_in_valid = 1'b0;
        tick();
        check("b2b_idle", 64'(b_out_valid), 64'd0);

        // ---------------- backpressure: LT 5<10 held ----------------
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_oper = ALU_LT; b_op1 = 8'd5; b_op2 = 8'd10;
        tick();
        check("lt_result", 64'({b_out_valid, b_result}), {55'd0, 1'b1, 8'd1});
        b_oper = ALU_ADD; b_op1 = 8'd1; b_op2 = 8'd2;   // pending op, held
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), 64'({b_out_valid, b_in_ready, b_result}),
                  {54'd0, 1'b1, 1'b0, 8'd1});
        end
        b_out_ready = 1'b1;
        tick();
        check("bp_pending", 64'({b_out_valid, b_result}), {55'd0, 1'b1, 8'd3});
        b_in_valid = 1'b0;
        tick();
        check("bp_idle", 64'(b_out_valid), 64'd0);

        // ---------------- signed overflow on WIDTH=8 ADD ----------------
        b_in_valid = 1'b1; b_oper = ALU_ADD; b_op1 = 8'h7F; b_op2 = 8'h01;
        tick();
        b_in_valid = 1'b0;
        check("add8_ovf", 64'({b_result, b_zero, b_carry, b_overflow, b_negative}),
              {52'd0, 8'h80, 4'b0011});
        tick();

        // ---------------- reset during MUL (WIDTH=8) ----------------
        b_in_valid = 1'b1; b_oper = ALU_MUL; b_op1 = 8'hFF; b_op2 = 8'hFF;
        tick();
        b_in_valid = 1'b0;
        tick();
        check("rmul_busy", 64'(b_busy), 64'd1);
        reset = 1'b1;
        #1;
        check("rmul_abort", 64'({b_out_valid, b_busy, b_result}), 64'd0);
        check("rmul_ready", 64'(b_in_ready), 64'd1);
        tick();
        reset = 1'b0;

        // ---------------- shifts ----------------
        b_in_valid = 1'b1; b_oper = ALU_SLL; b_op1 = 8'h81; b_op2 = 8'd1;
        tick();
        check("sll1", 64'({b_out_valid, b_result}), {55'd0, 1'b1, 8'h02});
        b_op2 = 8'd9;
        tick();
        check("sll9", 64'({b_result, b_zero}), {55'd0, 8'h00, 1'b1});
        b_op2 = 8'd8;
        tick();
        check("sll8", 64'(b_result), 64'd0);
        b_oper = ALU_SRL; b_op2 = 8'd7;
        tick();
        check("srl7", 64'(b_result), 64'd1);
        b_op2 = 8'd3;
        tick();
        check("srl3", 64'(b_result), 64'h10);
        b_in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
